// File: rtl/sdram_dev_model.sv
// Single-chip SDR SDRAM responder: command decode, per-bank row tracking, CAS-latency
// read pipeline, BL1/BL2 sequential bursts, byte-masked writes and sticky protocol errors.
module sdram_dev_model #(
  parameter int unsigned COL_WIDTH      = 9,
  parameter int unsigned ROW_WIDTH      = 13,
  parameter int unsigned BANK_WIDTH     = 2,
  parameter int unsigned MODEL_ROW_BITS = 4,
  parameter int unsigned TRCD_CK        = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cke,
  input  logic                  i_cs,
  input  logic [2:0]            i_cmd,
  input  logic [1:0]            i_dqm,
  input  logic [ROW_WIDTH-1:0]  i_addr,
  input  logic [BANK_WIDTH-1:0] i_ba,
  input  logic [15:0]           i_write_data,
  input  logic                  i_wr_en,
  output logic [15:0]           o_read_data,
  output logic                  o_read_valid,
  output logic                  o_mode_ok,
  output logic [15:0]           o_refresh_cnt,
  output logic [5:0]            o_err
);
  localparam int unsigned NUM_BANKS = 1 << BANK_WIDTH;
  localparam int unsigned IDX_W     = BANK_WIDTH + MODEL_ROW_BITS + COL_WIDTH;
  localparam int unsigned DEPTH     = 1 << IDX_W;
  localparam int unsigned TRCD_W    = (TRCD_CK < 1) ? 1 : $clog2(TRCD_CK + 1);

  typedef enum logic [2:0] {
    CMD_MRS = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_BST = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;

  logic [15:0]               r_mem  [DEPTH];
  logic [NUM_BANKS-1:0]      r_open;
  logic [MODEL_ROW_BITS-1:0] r_row  [NUM_BANKS];
  logic [TRCD_W-1:0]         r_trcd [NUM_BANKS];
  logic [2:0]                r_cl;
  logic                      r_bl2;
  logic                      r_rd_pend;
  logic                      r_rd_second;
  logic [2:0]                r_rd_wait;
  logic [IDX_W-1:0]          r_rd_idx;
  logic                      r_wr_pend;
  logic [IDX_W-1:0]          r_wr_idx;
  logic                      r_ap_pend;
  logic [BANK_WIDTH-1:0]     r_ap_bank;

  cmd_e             w_cmd;
  logic             w_dec;
  logic             w_bank_open;
  logic             w_any_open;
  logic             w_trcd_short;
  logic             w_mrs_ok;
  logic             w_ap;
  logic             w_rw_go;
  logic             w_bus_cmd;
  logic [IDX_W-1:0] w_base_idx;
  logic [IDX_W-1:0] w_pair_idx;
  logic [IDX_W-1:0] w_rd_pair;
  logic             w_mem_we;
  logic [IDX_W-1:0] w_mem_idx;
  logic             w_unused;

  assign w_unused = ^i_addr;

  // Command decode and address formation
  always_comb begin
    w_cmd        = cmd_e'(i_cmd);
    w_dec        = i_cke & ~i_cs;
    w_bank_open  = r_open[i_ba];
    w_any_open   = |r_open;
    w_trcd_short = r_trcd[i_ba] < TRCD_W'(TRCD_CK);
    w_ap         = i_addr[10];
    w_mrs_ok     = ((i_addr[6:4] == 3'd2) || (i_addr[6:4] == 3'd3)) && !i_addr[3] &&
                   (i_addr[2:1] == 2'b00);
    w_bus_cmd    = w_dec && ((w_cmd == CMD_RD) || (w_cmd == CMD_WR) || (w_cmd == CMD_BST));
    w_rw_go      = w_dec && ((w_cmd == CMD_RD) || (w_cmd == CMD_WR)) && o_mode_ok && w_bank_open;
    w_base_idx   = {i_ba, r_row[i_ba], i_addr[COL_WIDTH-1:0]};
    w_pair_idx   = {w_base_idx[IDX_W-1:1], ~w_base_idx[0]};
    w_rd_pair    = {r_rd_idx[IDX_W-1:1], ~r_rd_idx[0]};
  end

  // Write port: a new WR's first beat, else the pending second beat of a BL2 write
  always_comb begin
    w_mem_we  = 1'b0;
    w_mem_idx = r_wr_idx;
    if (!i_rst && w_rw_go && (w_cmd == CMD_WR) && i_wr_en) begin
      w_mem_we  = 1'b1;
      w_mem_idx = w_base_idx;
    end else if (!i_rst && i_cke && r_wr_pend && i_wr_en && !w_bus_cmd) begin
      w_mem_we  = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      if (!i_dqm[0]) r_mem[w_mem_idx][7:0]  <= i_write_data[7:0];
      if (!i_dqm[1]) r_mem[w_mem_idx][15:8] <= i_write_data[15:8];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_read_data   <= 16'h0000;
      o_read_valid  <= 1'b0;
      o_mode_ok     <= 1'b0;
      o_refresh_cnt <= 16'h0000;
      o_err         <= 6'b000000;
      r_open        <= '0;
      r_cl          <= 3'd2;
      r_bl2         <= 1'b0;
      r_rd_pend     <= 1'b0;
      r_rd_second   <= 1'b0;
      r_rd_wait     <= 3'd0;
      r_rd_idx      <= '0;
      r_wr_pend     <= 1'b0;
      r_wr_idx      <= '0;
      r_ap_pend     <= 1'b0;
      r_ap_bank     <= '0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        r_row[BANK_WIDTH'(b)]  <= '0;
        r_trcd[BANK_WIDTH'(b)] <= '0;
      end
    end else if (i_cke) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        if (r_trcd[BANK_WIDTH'(b)] < TRCD_W'(TRCD_CK))
          r_trcd[BANK_WIDTH'(b)] <= r_trcd[BANK_WIDTH'(b)] + TRCD_W'(1);
      end

      // Read pipeline: count down CAS latency, then present one word per clock
      o_read_valid <= 1'b0;
      o_read_data  <= 16'h0000;
      if (r_rd_pend) begin
        if (r_rd_wait == 3'd0) begin
          o_read_valid <= 1'b1;
          o_read_data  <= r_mem[r_rd_idx];
          if (r_rd_second) begin
            r_rd_idx    <= w_rd_pair;
            r_rd_second <= 1'b0;
          end else begin
            r_rd_pend <= 1'b0;
          end
        end else begin
          r_rd_wait <= r_rd_wait - 3'd1;
        end
      end

      r_wr_pend <= 1'b0;
      if (r_ap_pend) begin
        r_open[r_ap_bank] <= 1'b0;
        r_ap_pend         <= 1'b0;
      end

      if (w_dec) begin
        case (w_cmd)
          CMD_MRS: begin
            if (w_any_open) o_err[3] <= 1'b1;
            if (w_mrs_ok) begin
              r_cl      <= i_addr[6:4];
              r_bl2     <= i_addr[0];
              o_mode_ok <= 1'b1;
            end else begin
              o_err[4] <= 1'b1;
            end
          end
          CMD_REF: begin
            o_refresh_cnt <= o_refresh_cnt + 16'd1;
            if (w_any_open) o_err[1] <= 1'b1;
          end
          CMD_PRE: begin
            if (w_ap) r_open <= '0;
            else      r_open[i_ba] <= 1'b0;
          end
          CMD_ACT: begin
            if (!o_mode_ok) begin
              o_err[0] <= 1'b1;
            end else begin
              if (w_bank_open) o_err[1] <= 1'b1;
              r_open[i_ba] <= 1'b1;
              r_row[i_ba]  <= i_addr[MODEL_ROW_BITS-1:0];
              r_trcd[i_ba] <= TRCD_W'(1);
            end
          end
          CMD_RD, CMD_WR: begin
            if (!o_mode_ok) begin
              o_err[0] <= 1'b1;
            end else if (!w_bank_open) begin
              o_err[2] <= 1'b1;
            end else begin
              if (w_trcd_short) o_err[5] <= 1'b1;
              if (w_cmd == CMD_RD) begin
                r_rd_pend   <= 1'b1;
                r_rd_wait   <= r_cl - 3'd1;
                r_rd_idx    <= w_base_idx;
                r_rd_second <= r_bl2;
              end else begin
                r_rd_pend <= 1'b0;
                r_wr_pend <= r_bl2;
                r_wr_idx  <= w_pair_idx;
              end
              // Auto-precharge closes the bank once the last beat has been issued
              if (w_ap) begin
                if (r_bl2) begin
                  r_ap_pend <= 1'b1;
                  r_ap_bank <= i_ba;
                end else begin
                  r_open[i_ba] <= 1'b0;
                end
              end
            end
          end
          CMD_BST: begin
            r_rd_pend <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
